// File: rtl/cache_line_ram_pkg.sv
// Shared types and helpers for the cache line data array.
// Holds the clear-sequencer state enum, a clog2 helper and default geometry.
package cache_line_ram_pkg;

  localparam int DEF_INDEX_W    = 8;
  localparam int DEF_WORD_BYTES = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Ceiling log2, never below 1 so a one-byte word still has an offset bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  localparam int DEF_OFF_W = clog2_min1(DEF_WORD_BYTES);

endpackage

// File: rtl/cache_line_ram_clr_fsm.sv
// Clear sequencer: walks every line index after reset or a flush, driving a zero-write strobe.
//   state    | meaning
//   ST_CLEAR | writing zero to line r_clr_cnt, busy asserted
//   ST_READY | array available to the request port
module cache_line_ram_clr_fsm
  import cache_line_ram_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_clr_we,
  output logic [INDEX_W-1:0] o_clr_idx
);

  clr_state_e         r_state;
  logic [INDEX_W-1:0] r_clr_cnt;
  logic               r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // A flush mid-sweep restarts from line 0 rather than finishing the pass.
          if (i_flush) begin
            r_clr_cnt <= '0;
          end else if (r_clr_cnt == {INDEX_W{1'b1}}) begin
            r_state   <= ST_READY;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + INDEX_W'(1);
          end
        end
        ST_READY: begin
          if (i_flush) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_busy    <= 1'b1;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_we  = (r_state == ST_CLEAR);
  assign o_clr_idx = r_clr_cnt;

endmodule

// File: rtl/cache_line_ram.sv
// Cache line data array with byte-enable writes, 1-cycle registered reads and a built-in clear sweep.
// Optional per-byte even parity is enabled with `define CACHE_LINE_RAM_PARITY_EN.
module cache_line_ram
  import cache_line_ram_pkg::*;
#(
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int OFF_W      = clog2_min1(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    busy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [INDEX_W-1:0]      req_index,
  input  logic [OFF_W-1:0]        req_offset,
  input  logic [WORD_BYTES-1:0]   req_be,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_word,
  output logic [7:0]              rsp_byte,
  output logic [WORD_BYTES-1:0]   rsp_perr
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int DEPTH = 1 << INDEX_W;

  logic               w_busy;
  logic               w_clr_we;
  logic [INDEX_W-1:0] w_clr_idx;
  logic               w_accept;
  logic               w_wr;
  logic               w_rd;
  logic [DW-1:0]      w_rd_word;
  logic [7:0]         w_rd_byte;

  logic [DW-1:0]      r_mem [DEPTH];
  logic               r_rsp_valid;
  logic [DW-1:0]      r_rsp_word;
  logic [7:0]         r_rsp_byte;

  cache_line_ram_clr_fsm #(
    .INDEX_W (INDEX_W)
  ) u_clr_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  assign busy      = w_busy;
  assign req_ready = !w_busy && !flush;
  assign w_accept  = req_valid && req_ready && !rst;
  assign w_wr      = w_accept && req_we;
  assign w_rd      = w_accept && !req_we;

  // Clear and port writes never coincide: the port is only ready outside the sweep.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (req_be[b]) r_mem[req_index][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[req_index];

  always_comb begin
    w_rd_byte = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (req_offset == OFF_W'(b)) w_rd_byte = w_rd_word[8*b +: 8];
    end
  end

  // Data registers hold their last value between responses; only the valid flag pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_word  <= '0;
      r_rsp_byte  <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) begin
        r_rsp_word <= w_rd_word;
        r_rsp_byte <= w_rd_byte;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_word  = r_rsp_word;
  assign rsp_byte  = r_rsp_byte;

`ifdef CACHE_LINE_RAM_PARITY_EN
  logic [WORD_BYTES-1:0] r_par [DEPTH];
  logic [WORD_BYTES-1:0] w_perr;
  logic [WORD_BYTES-1:0] r_rsp_perr;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[w_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (req_be[b]) r_par[req_index][b] <= ^req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_perr = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      w_perr[b] = r_par[req_index][b] ^ (^w_rd_word[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rsp_perr <= '0;
    else     r_rsp_perr <= w_rd ? w_perr : '0;
  end

  assign rsp_perr = r_rsp_perr;
`else
  assign rsp_perr = '0;
`endif

endmodule

// File: tb/tb_cache_line_ram.sv
// Scoreboard bench for cache_line_ram: reference line model, expected reads queued at issue.
module tb_cache_line_ram;

  localparam int INDEX_W = 8;
  localparam int WB      = 4;
  localparam int OFF_W   = 2;
  localparam int DW      = 32;
  localparam int DEPTH   = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              busy;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [INDEX_W-1:0] req_index = '0;
  logic [OFF_W-1:0]  req_offset = '0;
  logic [WB-1:0]     req_be = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_word;
  logic [7:0]        rsp_byte;
  logic [WB-1:0]     rsp_perr;

  typedef struct packed {
    logic [DW-1:0] word;
    logic [7:0]    byt;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            n_tests = 0;
  int            n_fail  = 0;

  cache_line_ram dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .busy       (busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_index  (req_index),
    .req_offset (req_offset),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_word   (rsp_word),
    .rsp_byte   (rsp_byte),
    .rsp_perr   (rsp_perr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Drive one accepted request for one cycle; returns at the negedge after the accepting edge.
  task automatic drive(input logic we, input logic [INDEX_W-1:0] idx, input logic [OFF_W-1:0] off,
                       input logic [WB-1:0] be, input logic [DW-1:0] wd);
    logic [DW-1:0] w;
    req_valid  = 1'b1;
    req_we     = we;
    req_index  = idx;
    req_offset = off;
    req_be     = be;
    req_wdata  = wd;
    if (we) begin
      w = model[idx];
      for (int b = 0; b < WB; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      model[idx] = w;
    end else begin
      w = model[idx];
      sb.push_back(exp_t'{word: w, byt: w[8*off +: 8]});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL %s: busy cycles got %0d expected 256", name, n);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: req_ready got %b expected 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [INDEX_W-1:0] idxs [4];
    idxs[0] = 8'h00; idxs[1] = 8'h10; idxs[2] = 8'hFF; idxs[3] = 8'h7E;
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_word !== 32'h0 || rsp_byte !== 8'h0 ||
        rsp_perr !== 4'h0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rv=%b word=%h byte=%h perr=%b ready=%b expected 1 0 0 0 0 0",
               busy, rsp_valid, rsp_word, rsp_byte, rsp_perr, req_ready);
    end
    rst = 1'b0;
    model_clear();
    count_busy("reset_clear");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, idxs[i], OFF_W'(i), '0, '0);
      n_tests++;
      if (rsp_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL reset_read_valid: rsp_valid got %b expected 1", rsp_valid);
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        if (rsp_word !== e.word || rsp_byte !== e.byt || rsp_perr !== 4'h0) begin
          n_fail++;
          $display("FAIL reset_read: word=%h byte=%h perr=%b expected %h %h 0000",
                   rsp_word, rsp_byte, rsp_perr, e.word, e.byt);
        end
      end
    end
    idle();
  endtask

  task automatic test_full_write();
    exp_t e;
    drive(1'b1, 8'h10, 2'd0, 4'b1111, 32'hA1B2C3D4);
    drive(1'b0, 8'h10, 2'd2, 4'b0000, 32'h0);
    idle();
    n_tests++;
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'h0, byt: 8'h0};
    if (rsp_valid !== 1'b1 || rsp_word !== 32'hA1B2C3D4 || rsp_byte !== 8'hB2 ||
        rsp_word !== e.word || rsp_byte !== e.byt) begin
      n_fail++;
      $display("FAIL full_write: rv=%b word=%h byte=%h expected 1 a1b2c3d4 b2", rsp_valid, rsp_word, rsp_byte);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_word !== 32'hA1B2C3D4) begin
      n_fail++;
      $display("FAIL rsp_hold: rv=%b word=%h expected 0 a1b2c3d4", rsp_valid, rsp_word);
    end
  endtask

  task automatic test_partial_write();
    exp_t e;
    drive(1'b1, 8'h10, 2'd0, 4'b0001, 32'h000000EE);
    drive(1'b0, 8'h10, 2'd0, 4'b0000, 32'h0);
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'h0, byt: 8'h0};
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_word !== 32'hA1B2C3EE || rsp_byte !== 8'hEE || rsp_word !== e.word) begin
      n_fail++;
      $display("FAIL partial_write: rv=%b word=%h byte=%h expected 1 a1b2c3ee ee", rsp_valid, rsp_word, rsp_byte);
    end
    drive(1'b1, 8'h10, 2'd0, 4'b0000, 32'hFFFFFFFF);
    drive(1'b0, 8'h10, 2'd3, 4'b0000, 32'h0);
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'h0, byt: 8'h0};
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_word !== 32'hA1B2C3EE || rsp_byte !== 8'hA1 || rsp_byte !== e.byt) begin
      n_fail++;
      $display("FAIL be_zero_write: rv=%b word=%h byte=%h expected 1 a1b2c3ee a1", rsp_valid, rsp_word, rsp_byte);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(1'b1, 8'h05, 2'd0, 4'b1111, 32'h5A5A1234);
    drive(1'b0, 8'h05, 2'd1, 4'b0000, 32'h0);
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'h0, byt: 8'h0};
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_word !== 32'h5A5A1234 || rsp_byte !== 8'h12 || rsp_word !== e.word) begin
      n_fail++;
      $display("FAIL back_to_back: rv=%b word=%h byte=%h expected 1 5a5a1234 12", rsp_valid, rsp_word, rsp_byte);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e;
    logic               we;
    logic [INDEX_W-1:0] idx;
    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      idx = INDEX_W'($urandom_range(0, 7));
      drive(we, idx, OFF_W'($urandom_range(0, 3)), WB'($urandom_range(0, 15)), 32'($urandom));
      n_tests++;
      if (we) begin
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL random_wr_valid[%0d]: rsp_valid got %b expected 0", i, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL random_rd_valid[%0d]: rsp_valid got %b expected 1", i, rsp_valid);
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        if (rsp_word !== e.word || rsp_byte !== e.byt || rsp_perr !== 4'h0) begin
          n_fail++;
          $display("FAIL random_rd[%0d]: word=%h byte=%h perr=%b expected %h %h 0000",
                   i, rsp_word, rsp_byte, rsp_perr, e.word, e.byt);
        end
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_flush();
    exp_t e;
    flush      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_index  = 8'h10;
    req_be     = 4'b1111;
    req_wdata  = 32'hFFFFFFFF;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: req_ready got %b expected 0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    idle();
    model_clear();
    count_busy("flush_clear");
    drive(1'b0, 8'h10, 2'd2, 4'b0000, 32'h0);
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'hDEAD, byt: 8'hAD};
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_word !== 32'h0 || rsp_byte !== 8'h0 || rsp_word !== e.word) begin
      n_fail++;
      $display("FAIL flush_read: rv=%b word=%h byte=%h expected 1 00000000 00", rsp_valid, rsp_word, rsp_byte);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_mid_clear();
    drive(1'b1, 8'h07, 2'd0, 4'b1111, 32'hCAFEF00D);
    idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (100) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_clear_busy: busy got %b expected 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    count_busy("flush_restart");
  endtask

  task automatic test_rst_mid_read();
    exp_t e;
    drive(1'b1, 8'h20, 2'd0, 4'b1111, 32'h11223344);
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_index  = 8'h20;
    @(negedge clk);
    idle();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_read: rv=%b busy=%b expected 0 1", rsp_valid, busy);
    end
    rst = 1'b0;
    model_clear();
    count_busy("rst_restart");
    drive(1'b0, 8'h20, 2'd1, 4'b0000, 32'h0);
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'{word: 32'hDEAD, byt: 8'hAD};
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_word !== e.word || rsp_byte !== e.byt) begin
      n_fail++;
      $display("FAIL rst_read: rv=%b word=%h byte=%h expected 1 %h %h", rsp_valid, rsp_word, rsp_byte, e.word, e.byt);
    end
    @(negedge clk);
  endtask

  task automatic test_parity();
    logic [WB-1:0] exp_perr;
    drive(1'b1, 8'h03, 2'd0, 4'b1111, 32'h0F0F0F0F);
    idle();
    @(negedge clk);
`ifdef CACHE_LINE_RAM_PARITY_EN
    dut.r_mem[3][9] = ~dut.r_mem[3][9];
    exp_perr = 4'b0010;
`else
    exp_perr = 4'b0000;
`endif
    drive(1'b0, 8'h03, 2'd1, 4'b0000, 32'h0);
    idle();
    if (sb.size() != 0) void'(sb.pop_front());
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_perr !== exp_perr) begin
      n_fail++;
      $display("FAIL parity: rv=%b perr=%b expected 1 %b", rsp_valid, rsp_perr, exp_perr);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_perr !== 4'b0000) begin
      n_fail++;
      $display("FAIL parity_idle: perr=%b expected 0000", rsp_perr);
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_full_write();
    test_partial_write();
    test_back_to_back();
    test_random();
    test_flush();
    test_flush_mid_clear();
    test_rst_mid_read();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
